// File: rtl/cmp_sequencer_if.sv
// Operand-pair sequencer bus: byte stream in, operands and enable out to the
// comparator, comparator result back, and the captured-result handshake.
interface cmp_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cmp_en;
  logic       cmp_greater;
  logic       res_greater;
  logic       res_valid;
  logic       res_ready;

  // Environment side: byte producer, comparator and result consumer.
  modport master (
    output in_data, in_valid, flush, cmp_greater, res_ready,
    input  in_ready, op_a, op_b, cmp_en, res_greater, res_valid
  );

  // Sequencer side.
  modport slave (
    input  in_data, in_valid, flush, cmp_greater, res_ready,
    output in_ready, op_a, op_b, cmp_en, res_greater, res_valid
  );
endinterface

// File: rtl/cmp_sequencer.sv
// Loads an operand pair (A then B), strobes an external a>b comparator and
// holds the captured result. Defining CMP_COUNT_EN adds a saturating counter of greater results.
module cmp_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_sequencer_if.slave   bus
`ifdef CMP_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] gt_count
`endif
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   rdy_en;
  logic   load_a, load_b, capture, cmp_en_nxt;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cmp_sequencer: CNT_W must be at least 1");
  end

  // COMPARE lasts two cycles: the first lets the freshly loaded op_b reach
  // the comparator, the second raises cmp_en and the closing edge captures.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt     = state;
    load_a        = 1'b0;
    load_b        = 1'b0;
    capture       = 1'b0;
    cmp_en_nxt    = 1'b0;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;

    case (state)
      LOAD_A: begin
        bus.in_ready = rdy_en;
        if (bus.in_valid && rdy_en) begin
          load_a    = 1'b1;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        bus.in_ready = rdy_en;
        if (bus.in_valid && rdy_en) begin
          load_b    = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.cmp_en) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end else begin
          cmp_en_nxt = 1'b1;
        end
      end
      RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase

    // Flush beats everything, including a byte offered in the same cycle.
    if (bus.flush) begin
      state_nxt  = LOAD_A;
      load_a     = 1'b0;
      load_b     = 1'b0;
      capture    = 1'b0;
      cmp_en_nxt = 1'b0;
    end
  end

  // rdy_en keeps in_ready low while in reset and raises it at the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    if (!rst_n) begin
      state      <= LOAD_A;
      rdy_en     <= 1'b0;
      bus.cmp_en <= 1'b0;
    end else begin
      state      <= state_nxt;
      rdy_en     <= 1'b1;
      bus.cmp_en <= cmp_en_nxt;
    end
  end

  // Operands survive a flush; only a fresh load replaces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.op_a        <= '0;
      bus.op_b        <= '0;
      bus.res_greater <= 1'b0;
    end else begin
      if (load_a)  bus.op_a        <= bus.in_data;
      if (load_b)  bus.op_b        <= bus.in_data;
      if (capture) bus.res_greater <= bus.cmp_greater;
    end
  end

`ifdef CMP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_count <= '0;
    end else if (cnt_clr) begin
      gt_count <= '0;
    end else if (capture && bus.cmp_greater && (gt_count != {CNT_W{1'b1}})) begin
      gt_count <= gt_count + CNT_W'(1);
    end
  end
`endif

endmodule
